// File: rtl/mm_pkg.sv
// Shared constants and types for the 8x8 matrix-multiply datapath.
// Used by the result writer (write end) and the operand address generator (read end).
package mm_pkg;

   localparam int N    = 8;               // matrix dimension and dot-product length
   localparam int PW   = 16;              // signed product width
   localparam int OW   = 16;              // signed result word width
   localparam int AW   = 8;               // result memory address width
   localparam int IW   = $clog2(N);       // index width
   localparam int ACCW = PW + IW;         // accumulator width; N products of PW bits never overflow it

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } mm_wr_state_t;

   typedef logic [IW-1:0] mm_idx_t;

endpackage

// File: rtl/mm_result_writer_if.sv
// Product stream in, result-memory write port out.
// master: the side producing products and owning the result memory.
// slave:  the result writer.
interface mm_result_writer_if;
   import mm_pkg::*;

   logic          prod_valid;
   logic [PW-1:0] prod_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [OW-1:0] wr_data;

   modport master (
      output prod_valid, prod_data,
      input  wr_en, wr_addr, wr_data
   );

   modport slave (
      input  prod_valid, prod_data,
      output wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/mm_result_fit.sv
// Combinational ACCW -> OW narrowing of a finished dot product.
// Build option: define ACC_SAT_EN to clamp to the signed OW range;
// otherwise the low OW bits are kept (two's-complement truncation).
module mm_result_fit
   import mm_pkg::*;
(
   input  logic signed [ACCW-1:0] acc,
   output logic        [OW-1:0]   res
);

`ifdef ACC_SAT_EN
   localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   // clamp out-of-range sums to the nearest representable OW value
   always_comb begin
      res = acc[OW-1:0];
      if (acc > MAX_V) begin
         res = {1'b0, {(OW-1){1'b1}}};
      end else if (acc < MIN_V) begin
         res = {1'b1, {(OW-1){1'b0}}};
      end
   end
`else
   logic unused_hi;

   // keep the low OW bits; upper accumulator bits are intentionally dropped
   always_comb begin
      res       = acc[OW-1:0];
      unused_hi = ^acc[ACCW-1:OW];
   end
`endif

endmodule

// File: rtl/mm_result_writer.sv
// Result write-back for the 8x8 matrix multiply.
// Accumulates N products per C[i][j] (stream order i, j, k), writes each
// result at column-major address j*N+i one cycle after its last product,
// and flags done after N*N writes. Build option ACC_SAT_EN selects
// saturating rather than truncating narrowing of the result (see mm_result_fit).
module mm_result_writer
   import mm_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   mm_result_writer_if.slave        bus,
   output logic                     busy,
   output logic                     done,
   output logic                     drop
);

   mm_wr_state_t state, state_next;

   mm_idx_t k, j, i;
   mm_idx_t k_next, j_next, i_next;

   logic signed [ACCW-1:0] acc, acc_next;
   logic signed [ACCW-1:0] prod_ext;
   logic signed [ACCW-1:0] sum;

   logic          wr_en_q, wr_en_next;
   logic [AW-1:0] wr_addr_q, wr_addr_next;
   logic [OW-1:0] wr_data_q, wr_data_next;
   logic [OW-1:0] fit_out;

   logic busy_next, done_next, drop_next;

   assign prod_ext = {{(ACCW-PW){bus.prod_data[PW-1]}}, bus.prod_data};

   // k==0 starts a fresh dot product, so the stale accumulator is ignored
   assign sum = (k == '0) ? prod_ext : acc + prod_ext;

   mm_result_fit u_fit (
      .acc (sum),
      .res (fit_out)
   );

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // next state, counters, accumulator and registered outputs
   always_comb begin
      state_next   = state;
      k_next       = k;
      j_next       = j;
      i_next       = i;
      acc_next     = acc;
      wr_en_next   = 1'b0;
      wr_addr_next = wr_addr_q;
      wr_data_next = wr_data_q;
      done_next    = done;
      drop_next    = 1'b0;

      if (start) begin
         state_next = ACCUM;
         k_next     = '0;
         j_next     = '0;
         i_next     = '0;
         acc_next   = '0;
         done_next  = 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.prod_valid) begin
                  if (k == mm_idx_t'(N-1)) begin
                     wr_en_next   = 1'b1;
                     wr_addr_next = AW'(int'(j) * N + int'(i));
                     wr_data_next = fit_out;
                     k_next       = '0;
                     if (j == mm_idx_t'(N-1)) begin
                        j_next = '0;
                        if (i == mm_idx_t'(N-1)) begin
                           i_next     = '0;
                           state_next = DONE;
                           done_next  = 1'b1;
                        end else begin
                           i_next = i + mm_idx_t'(1);
                        end
                     end else begin
                        j_next = j + mm_idx_t'(1);
                     end
                  end else begin
                     acc_next = sum;
                     k_next   = k + mm_idx_t'(1);
                  end
               end
            end
            DONE: begin
               drop_next = bus.prod_valid;
            end
            default: begin
               state_next = ACCUM;
            end
         endcase
      end

      busy_next = (state_next == ACCUM);
   end

   // datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k         <= '0;
         j         <= '0;
         i         <= '0;
         acc       <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         drop      <= 1'b0;
      end else begin
         k         <= k_next;
         j         <= j_next;
         i         <= i_next;
         acc       <= acc_next;
         wr_en_q   <= wr_en_next;
         wr_addr_q <= wr_addr_next;
         wr_data_q <= wr_data_next;
         busy      <= busy_next;
         done      <= done_next;
         drop      <= drop_next;
      end
   end

endmodule

// File: tb/tb_mm_result_writer.sv
// Self-checking bench for mm_result_writer against a product-count model:
// the model counts accepted products, sums each group of N, and derives the
// write address from the dot-product index in i-outer / j-middle order.
module tb_mm_result_writer;
   import mm_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy, done, drop;

   mm_result_writer_if bus ();

   mm_result_writer dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus.slave),
      .busy  (busy),
      .done  (done),
      .drop  (drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_p;
   int          m_sum;
   logic        m_done, m_busy, m_wr_en, m_drop;
   logic [7:0]  m_addr;
   logic [15:0] m_data;

   function automatic logic [15:0] fit_ref(input int s);
      logic [31:0] w;
`ifdef ACC_SAT_EN
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
`endif
      w = s;
      return w[15:0];
   endfunction

   function automatic logic [27:0] observed();
      return {bus.wr_en, bus.wr_addr, bus.wr_data, busy, done, drop};
   endfunction

   function automatic logic [27:0] expected();
      return {m_wr_en, m_addr, m_data, m_busy, m_done, m_drop};
   endfunction

   task automatic model_reset();
      m_p = 0; m_sum = 0; m_done = 1'b0; m_busy = 1'b0;
      m_wr_en = 1'b0; m_drop = 1'b0; m_addr = '0; m_data = '0;
   endtask

   // drive one cycle of inputs, advance the model across the edge, sample at +1
   task automatic step(input logic v, input int d, input logic st);
      int dot;
      bus.prod_valid = v;
      bus.prod_data  = d[15:0];
      start          = st;
      @(posedge clk);
      m_wr_en = 1'b0;
      m_drop  = 1'b0;
      if (st) begin
         m_p = 0; m_sum = 0; m_done = 1'b0;
      end else if (v) begin
         if (m_done) begin
            m_drop = 1'b1;
         end else begin
            m_sum += d;
            m_p++;
            if (m_p % N == 0) begin
               dot     = m_p / N - 1;
               m_wr_en = 1'b1;
               m_addr  = 8'((dot % N) * N + dot / N);
               m_data  = fit_ref(m_sum);
               m_sum   = 0;
               if (m_p == N * N * N) m_done = 1'b1;
            end
         end
      end
      m_busy = !m_done;
      #1;
      bus.prod_valid = 1'b0;
      start          = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; bus.prod_valid = 1'b0; bus.prod_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      if (observed() !== expected()) begin
         errors++; $display("FAIL reset_state: got %h exp %h", observed(), expected());
      end
      checks++;
      reset = 1'b0;
      step(1'b0, 0, 1'b0);
      if (busy !== 1'b1) begin
         errors++; $display("FAIL reset_busy: got %b exp 1", busy);
      end
      checks++;
   endtask

   task automatic test_all_ones();
      int writes = 0;
      for (int n = 0; n < N * N * N; n++) begin
         step(1'b1, 1, 1'b0);
         if (bus.wr_en === 1'b1) writes++;
         if (observed() !== expected()) begin
            errors++; $display("FAIL all_ones step %0d: got %h exp %h", n, observed(), expected());
         end
         checks++;
      end
      if (writes !== N * N) begin
         errors++; $display("FAIL all_ones_count: got %0d exp %0d", writes, N * N);
      end
      checks++;
      if (done !== 1'b1 || bus.wr_addr !== 8'd63) begin
         errors++; $display("FAIL all_ones_final: got done %b addr %0d exp 1 63", done, bus.wr_addr);
      end
      checks++;
   endtask

   task automatic test_drop_restart();
      for (int n = 0; n < 2; n++) begin
         step(1'b1, 7, 1'b0);
         if (observed() !== expected() || drop !== 1'b1) begin
            errors++; $display("FAIL drop %0d: got %h exp %h", n, observed(), expected());
         end
         checks++;
      end
      step(1'b0, 0, 1'b0);
      if (drop !== 1'b0 || done !== 1'b1 || bus.wr_en !== 1'b0) begin
         errors++; $display("FAIL drop_idle: got %h exp %h", observed(), expected());
      end
      checks++;
      step(1'b0, 0, 1'b1);
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL restart: got busy %b done %b exp 1 0", busy, done);
      end
      checks++;
      for (int n = 0; n < N * N * N; n++) begin
         step(1'b1, 1, 1'b0);
         if (observed() !== expected()) begin
            errors++; $display("FAIL rerun step %0d: got %h exp %h", n, observed(), expected());
         end
         checks++;
      end
   endtask

   task automatic test_gaps();
      step(1'b0, 0, 1'b1);
      for (int n = 0; n < N * N * N; n++) begin
         step(1'b1, (n % N) + 1, 1'b0);
         if (observed() !== expected()) begin
            errors++; $display("FAIL gaps step %0d: got %h exp %h", n, observed(), expected());
         end
         checks++;
         for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
            step(1'b0, 0, 1'b0);
            if (observed() !== expected()) begin
               errors++; $display("FAIL gaps idle %0d: got %h exp %h", n, observed(), expected());
            end
            checks++;
         end
      end
   endtask

   task automatic test_const(input int val);
      step(1'b0, 0, 1'b1);
      for (int n = 0; n < N * N * N; n++) begin
         step(1'b1, val, 1'b0);
         if (observed() !== expected()) begin
            errors++; $display("FAIL const %0d step %0d: got %h exp %h", val, n, observed(), expected());
         end
         checks++;
      end
   endtask

   task automatic test_random();
      int d;
      step(1'b0, 0, 1'b1);
      for (int n = 0; n < N * N * N; n++) begin
         d = int'($urandom_range(65535)) - 32768;
         step(1'b1, d, 1'b0);
         if (observed() !== expected()) begin
            errors++; $display("FAIL random step %0d: got %h exp %h", n, observed(), expected());
         end
         checks++;
         if ($urandom_range(3) == 0) begin
            step(1'b0, 0, 1'b0);
            if (observed() !== expected()) begin
               errors++; $display("FAIL random idle %0d: got %h exp %h", n, observed(), expected());
            end
            checks++;
         end
      end
   endtask

   task automatic test_start_mid();
      step(1'b0, 0, 1'b1);
      for (int n = 0; n < 19 * N + 3; n++) step(1'b1, n, 1'b0);
      step(1'b1, 99, 1'b1);
      if (observed() !== expected() || done !== 1'b0) begin
         errors++; $display("FAIL start_mid: got %h exp %h", observed(), expected());
      end
      checks++;
      for (int n = 0; n < N; n++) begin
         step(1'b1, 3, 1'b0);
         if (observed() !== expected()) begin
            errors++; $display("FAIL start_mid_next %0d: got %h exp %h", n, observed(), expected());
         end
         checks++;
      end
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd0 || bus.wr_data !== 16'd24) begin
         errors++; $display("FAIL start_mid_write: got en %b addr %0d data %h exp 1 0 0018",
                            bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      step(1'b0, 0, 1'b1);
      for (int n = 0; n < 19 * N + 3; n++) step(1'b1, 2, 1'b0);
      bus.prod_valid = 1'b1;
      reset          = 1'b1;
      model_reset();
      #1;
      if (observed() !== expected()) begin
         errors++; $display("FAIL reset_mid_async: got %h exp %h", observed(), expected());
      end
      checks++;
      @(posedge clk);
      #1;
      if (observed() !== expected()) begin
         errors++; $display("FAIL reset_mid_edge: got %h exp %h", observed(), expected());
      end
      checks++;
      bus.prod_valid = 1'b0;
      reset          = 1'b0;
      step(1'b0, 0, 1'b0);
      for (int n = 0; n < N; n++) begin
         step(1'b1, -5, 1'b0);
         if (observed() !== expected()) begin
            errors++; $display("FAIL reset_mid_next %0d: got %h exp %h", n, observed(), expected());
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_drop_restart();
      test_gaps();
      test_const(-1);
      test_const(32767);
      test_random();
      test_start_mid();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish exp finish");
      $fatal(1, "timeout");
   end

endmodule
